// File: rtl/dict_pkg.sv
// ---------------------------------------------------------------------------
// dict_pkg
//   Shared definitions for the dictionary preload controller:
//   - dict_ld_state_t : preload FSM state encoding
//   - default widths for the two dictionary profiles (R-type 5/10, I-type 6/12)
//   - DICT_DEPTH(kw)  : entries per dictionary for a given key width
//   - dict_sel_width  : width of an index selecting one of n items (min 1 bit)
// ---------------------------------------------------------------------------
package dict_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_LOAD  = 2'd2,
      ST_DONE  = 2'd3
   } dict_ld_state_t;

   localparam int unsigned R_KEY_WIDTH    = 5;
   localparam int unsigned R_VAL_WIDTH    = 10;
   localparam int unsigned I_KEY_WIDTH    = 6;
   localparam int unsigned I_VAL_WIDTH    = 12;
   localparam int unsigned DEF_NUM_FIELDS = 3;

   function automatic int unsigned DICT_DEPTH(input int unsigned kw);
      return 32'd1 << kw;
   endfunction

   // A single field still needs a one-bit index register.
   function automatic int unsigned dict_sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dict_ld_counter.sv
// ---------------------------------------------------------------------------
// dict_ld_counter
//   Field / entry position of the word currently on the dictionary write
//   port during a preload. The entry counter wraps DEPTH-1 -> 0 and carries
//   into the field index on the same edge, so consecutive fields are loaded
//   back to back.
//
// Ports
//   clk       : clock, rising edge
//   resetn    : asynchronous active-low reset
//   clear     : restart at field 0, entry 0 on the next edge
//   advance   : step to the next entry on the next edge
//   field_nxt : field index the next word belongs to (drives the one-hot
//               enable register in the parent)
//   last      : current word is the final entry of the final field
// ---------------------------------------------------------------------------
module dict_ld_counter
   import dict_pkg::*;
#(
   parameter int unsigned NUM_FIELDS = DEF_NUM_FIELDS,
   parameter int unsigned KEY_WIDTH  = I_KEY_WIDTH,
   parameter int unsigned FIELD_W    = dict_sel_width(NUM_FIELDS)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               clear,
   input  logic               advance,
   output logic [FIELD_W-1:0] field_nxt,
   output logic               last
);

   logic [FIELD_W-1:0]   field_idx;
   logic [KEY_WIDTH-1:0] entry;
   logic                 entry_wrap;

   assign entry_wrap = (entry == '1);
   assign field_nxt  = entry_wrap ? field_idx + 1'b1 : field_idx;
   assign last       = entry_wrap && (field_idx == FIELD_W'(NUM_FIELDS - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         field_idx <= '0;
         entry     <= '0;
      end else if (clear) begin
         field_idx <= '0;
         entry     <= '0;
      end else if (advance) begin
         entry     <= entry + 1'b1;
         field_idx <= field_nxt;
      end
   end

endmodule

// File: rtl/dict_preload_ctrl.sv
// ---------------------------------------------------------------------------
// dict_preload_ctrl
//   Start-up loader for the code-compression field dictionaries. Walks a
//   synchronous preload ROM (field f at f*DEPTH .. f*DEPTH+DEPTH-1) and
//   streams every word into its field's dictionary at one word per cycle,
//   with no gaps inside or between fields. dict_ready goes high once every
//   field holds a complete load; load_sum is the XOR of all words written.
//
// Ports
//   clk          : clock, rising edge
//   resetn       : asynchronous active-low reset
//   start        : level load request, honoured in IDLE or DONE only
//   rom_en       : ROM read enable (registered)
//   rom_addr     : ROM word address (registered)
//   rom_data     : ROM read data, one cycle after the sampling edge
//   write_enable : per-field dictionary write enable, one-hot or zero
//   write_val    : dictionary entry data, straight from rom_data
//   busy         : load in progress
//   dict_ready   : all dictionaries hold a complete load
//   load_sum     : XOR of every word written during the last load
// ---------------------------------------------------------------------------
module dict_preload_ctrl
   import dict_pkg::*;
#(
   parameter int unsigned NUM_FIELDS = DEF_NUM_FIELDS,
   parameter int unsigned KEY_WIDTH  = I_KEY_WIDTH,
   parameter int unsigned VAL_WIDTH  = I_VAL_WIDTH,
   parameter int unsigned ROM_AW     = $clog2(NUM_FIELDS * DICT_DEPTH(KEY_WIDTH))
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   output logic                  rom_en,
   output logic [ROM_AW-1:0]     rom_addr,
   input  logic [VAL_WIDTH-1:0]  rom_data,
   output logic [NUM_FIELDS-1:0] write_enable,
   output logic [VAL_WIDTH-1:0]  write_val,
   output logic                  busy,
   output logic                  dict_ready,
   output logic [VAL_WIDTH-1:0]  load_sum
);

   localparam int unsigned DEPTH   = DICT_DEPTH(KEY_WIDTH);
   localparam int unsigned TOTAL   = NUM_FIELDS * DEPTH;
   localparam int unsigned FIELD_W = dict_sel_width(NUM_FIELDS);
   localparam logic [ROM_AW-1:0] LAST_ADDR = ROM_AW'(TOTAL - 1);

   dict_ld_state_t     state;
   logic [FIELD_W-1:0] field_nxt;
   logic               last;
   logic               cnt_clear;
   logic               cnt_advance;

   // Counter tracks the word currently on write_val: zeroed while priming,
   // stepped once per streamed word.
   assign cnt_clear   = (state == ST_PRIME);
   assign cnt_advance = (state == ST_LOAD);

   dict_ld_counter #(
      .NUM_FIELDS (NUM_FIELDS),
      .KEY_WIDTH  (KEY_WIDTH),
      .FIELD_W    (FIELD_W)
   ) u_counter (
      .clk       (clk),
      .resetn    (resetn),
      .clear     (cnt_clear),
      .advance   (cnt_advance),
      .field_nxt (field_nxt),
      .last      (last)
   );

   assign write_val = rom_data;

   // The ROM address runs one word ahead of write_val to hide the ROM read
   // latency. It stops at the final word; the edge that finds it there also
   // drops rom_en, which still lets that final read complete.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= ST_IDLE;
         rom_en       <= 1'b0;
         rom_addr     <= '0;
         write_enable <= '0;
         busy         <= 1'b0;
         dict_ready   <= 1'b0;
         load_sum     <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_PRIME;
                  rom_en     <= 1'b1;
                  rom_addr   <= '0;
                  busy       <= 1'b1;
                  dict_ready <= 1'b0;
                  load_sum   <= '0;
               end
            end

            ST_PRIME: begin
               state        <= ST_LOAD;
               rom_addr     <= rom_addr + 1'b1;
               write_enable <= NUM_FIELDS'(1);
            end

            ST_LOAD: begin
               load_sum <= load_sum ^ rom_data;
               if (rom_addr < LAST_ADDR) begin
                  rom_addr <= rom_addr + 1'b1;
               end else begin
                  rom_en <= 1'b0;
               end
               if (last) begin
                  state        <= ST_DONE;
                  write_enable <= '0;
                  busy         <= 1'b0;
                  dict_ready   <= 1'b1;
               end else begin
                  // Field carry and entry wrap land on the same edge, so the
                  // enable hops to the next field without an idle cycle.
                  write_enable <= NUM_FIELDS'(1) << field_nxt;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dict_preload_ctrl.sv
module tb_dict_preload_ctrl;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit sel      = 1'b0;   // 0: 3x64x12 instance, 1: 1x32x10 instance
   bit mode_a   = 1'b0;   // ROM contents of the 3-field instance

   // 3 fields, KEY_WIDTH 6, VAL_WIDTH 12
   logic        start_a, rom_en_a, busy_a, ready_a;
   logic [7:0]  rom_addr_a;
   logic [11:0] rom_data_a, wv_a, sum_a;
   logic [2:0]  we_a;

   // 1 field, KEY_WIDTH 5, VAL_WIDTH 10
   logic        start_r, rom_en_r, busy_r, ready_r;
   logic [4:0]  rom_addr_r;
   logic [9:0]  rom_data_r, wv_r, sum_r;
   logic [0:0]  we_r;

   dict_preload_ctrl #(.NUM_FIELDS(3), .KEY_WIDTH(6), .VAL_WIDTH(12)) dut (
      .clk(clk), .resetn(resetn), .start(start_a), .rom_en(rom_en_a),
      .rom_addr(rom_addr_a), .rom_data(rom_data_a), .write_enable(we_a),
      .write_val(wv_a), .busy(busy_a), .dict_ready(ready_a), .load_sum(sum_a));

   dict_preload_ctrl #(.NUM_FIELDS(1), .KEY_WIDTH(5), .VAL_WIDTH(10)) dut_r (
      .clk(clk), .resetn(resetn), .start(start_r), .rom_en(rom_en_r),
      .rom_addr(rom_addr_r), .rom_data(rom_data_r), .write_enable(we_r),
      .write_val(wv_r), .busy(busy_r), .dict_ready(ready_r), .load_sum(sum_r));

   // ROM contents
   function automatic int unsigned word(input bit s, input int n);
      if (s)           return 32'((n + 1) & 'h3FF);
      else if (mode_a) return 32'(('hFFF - n) & 'hFFF);
      else             return 32'((n + 1) & 'hFFF);
   endfunction

   always @(posedge clk) begin
      if (rom_en_a) rom_data_a <= 12'(word(1'b0, 32'(rom_addr_a)));
      if (rom_en_r) rom_data_r <= 10'(word(1'b1, 32'(rom_addr_r)));
   end

   // Dictionary models: write index restarts whenever the enable is low
   logic [11:0] dict_a [3][64];
   logic [5:0]  idx_a  [3];
   logic [9:0]  dict_r [32];
   logic [4:0]  idx_r;

   always @(posedge clk) begin
      for (int f = 0; f < 3; f++) begin
         if (we_a[f]) begin
            dict_a[f][idx_a[f]] <= wv_a;
            idx_a[f] <= idx_a[f] + 6'd1;
         end else begin
            idx_a[f] <= 6'd0;
         end
      end
      if (we_r[0]) begin
         dict_r[idx_r] <= wv_r;
         idx_r <= idx_r + 5'd1;
      end else begin
         idx_r <= 5'd0;
      end
   end

   // Views of the selected instance
   int unsigned s_en, s_addr, s_busy, s_ready, s_sum, s_we;
   assign s_en    = sel ? 32'(rom_en_r)   : 32'(rom_en_a);
   assign s_addr  = sel ? 32'(rom_addr_r) : 32'(rom_addr_a);
   assign s_busy  = sel ? 32'(busy_r)     : 32'(busy_a);
   assign s_ready = sel ? 32'(ready_r)    : 32'(ready_a);
   assign s_sum   = sel ? 32'(sum_r)      : 32'(sum_a);
   assign s_we    = sel ? 32'(we_r)       : 32'(we_a);

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s (sel=%0d t=%0t): actual=0x%0h required=0x%0h", name, sel, $time, act, exp);
      end
   endtask

   // Scoreboard
   typedef struct {
      int unsigned we;
      int unsigned val;
      bit          first;
   } exp_t;

   exp_t        q_a[$];
   exp_t        q_r[$];
   int unsigned prev_we[2];

   task automatic observe(input bit s, input int unsigned we, input int unsigned val);
      exp_t e;
      int   n;
      chk("we_onehot", ($countones(we) <= 1) ? 1 : 0, 1);
      if (we != 0) begin
         n = s ? q_r.size() : q_a.size();
         chk("write_expected", (n > 0) ? 1 : 0, 1);
         if (n > 0) begin
            if (s) e = q_r.pop_front();
            else   e = q_a.pop_front();
            chk("write_enable", we, e.we);
            chk("write_val", val, e.val);
            if (we != prev_we[s]) chk("enable_rise_at_entry0", e.first ? 1 : 0, 1);
         end
      end
      prev_we[s] = we;
   endtask

   always @(negedge clk) begin
      if (resetn) begin
         observe(1'b0, 32'(we_a), 32'(wv_a));
         observe(1'b1, 32'(we_r), 32'(wv_r));
      end else begin
         prev_we[0] = 0;
         prev_we[1] = 0;
      end
   end

   // Stimulus
   task automatic set_start(input bit v);
      if (sel) start_r = v;
      else     start_a = v;
   endtask

   task automatic check_reset_vals();
      chk("rst_rom_en", s_en, 0);
      chk("rst_rom_addr", s_addr, 0);
      chk("rst_write_enable", s_we, 0);
      chk("rst_busy", s_busy, 0);
      chk("rst_dict_ready", s_ready, 0);
      chk("rst_load_sum", s_sum, 0);
   endtask

   // Entered #1 after E0. Walks edges E1..E(TOTAL+1), or stops after E(stop_at).
   task automatic load_body(input int stop_at, input int unsigned exp_sum);
      int   total, depth;
      exp_t e;
      total = sel ? 32 : 192;
      depth = sel ? 32 : 64;
      chk("busy_after_start", s_busy, 1);
      chk("ready_cleared", s_ready, 0);
      chk("rom_en_after_start", s_en, 1);
      chk("rom_addr_after_start", s_addr, 0);
      chk("sum_cleared", s_sum, 0);
      chk("we_idle_in_prime", s_we, 0);
      for (int n = 0; n < total; n++) begin
         e.we    = 32'd1 << (n / depth);
         e.val   = word(sel, n);
         e.first = ((n % depth) == 0);
         if (sel) q_r.push_back(e);
         else     q_a.push_back(e);
      end
      for (int n = 1; n <= total + 1; n++) begin
         @(posedge clk);
         #1;
         if (n <= total - 1) begin
            chk("rom_addr", s_addr, 32'(n));
            chk("rom_en", s_en, 1);
         end else begin
            chk("rom_addr_hold", s_addr, 32'(total - 1));
            chk("rom_en_off", s_en, 0);
         end
         if (n <= total) begin
            chk("busy_during_load", s_busy, 1);
            chk("ready_during_load", s_ready, 0);
         end else begin
            chk("busy_done", s_busy, 0);
            chk("ready_done", s_ready, 1);
            chk("we_done", s_we, 0);
            chk("load_sum", s_sum, exp_sum);
            chk("queue_drained", sel ? 32'(q_r.size()) : 32'(q_a.size()), 0);
         end
         if (n == stop_at) return;
      end
   endtask

   task automatic do_load(input bit hold, input int unsigned exp_sum);
      set_start(1'b1);
      @(posedge clk);
      #1;
      if (!hold) set_start(1'b0);
      load_body(0, exp_sum);
      if (hold) begin
         // start still high in DONE: the next edge must begin a reload
         @(posedge clk);
         #1;
         set_start(1'b0);
         load_body(0, exp_sum);
      end
   endtask

   task automatic check_dict_a(input int unsigned exp_f1k0);
      int mism = 0;
      for (int f = 0; f < 3; f++)
         for (int k = 0; k < 64; k++)
            if (32'(dict_a[f][k]) != word(1'b0, f * 64 + k)) mism++;
      chk("dict_contents_mismatches", 32'(mism), 0);
      chk("field1_key0", 32'(dict_a[1][0]), exp_f1k0);
   endtask

   task automatic check_dict_r();
      int mism = 0;
      for (int k = 0; k < 32; k++)
         if (32'(dict_r[k]) != word(1'b1, k)) mism++;
      chk("r_dict_contents_mismatches", 32'(mism), 0);
      chk("r_key31", 32'(dict_r[31]), 32);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn  = 1'b0;
      start_a = 1'b0;
      start_r = 1'b0;
      #12;
      sel = 1'b0; check_reset_vals();
      sel = 1'b1; check_reset_vals();
      sel = 1'b0;
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Basic load: words n+1, XOR of 1..192 = 0xC0
      do_load(1'b0, 32'h0C0);
      check_dict_a(65);

      // start held high: one load, then an immediate reload from DONE
      do_load(1'b1, 32'h0C0);
      check_dict_a(65);

      // Reset while word 100 (field 1, entry 36) is on the write port
      set_start(1'b1);
      @(posedge clk);
      #1;
      set_start(1'b0);
      load_body(101, 0);
      #2 resetn = 1'b0;
      #1;
      check_reset_vals();
      q_a.delete();
      @(posedge clk);
      #2 resetn = 1'b1;
      @(posedge clk);
      #1;
      do_load(1'b0, 32'h0C0);
      check_dict_a(65);

      // New ROM contents 0xFFF-n: XOR over n=0..191 of ~n is 0
      mode_a = 1'b1;
      do_load(1'b0, 32'h000);
      check_dict_a(32'hFBF);

      // Single-field 32-entry instance: XOR of 1..32 = 0x20
      sel = 1'b1;
      do_load(1'b0, 32'h020);
      check_dict_r();

      @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dict_preload_ctrl.md
# dict_preload_ctrl

Sequences start-up loading of the field dictionaries used by the code-compression datapath. It walks a synchronous preload ROM and streams each field's entries into that field's dictionary through the dictionary write port (`write_enable` / `write_val`). The dictionary's internal write index resets whenever `write_enable` is low, so each field's entries are streamed with no gaps. The block raises `dict_ready` once every field is loaded; the compressor and decompressor gate their lookups on that signal.

## Interface
- `NUM_FIELDS`, default 3: number of dictionaries loaded, each with its own write enable.
- `KEY_WIDTH`, default 6: dictionary index width. DEPTH = 2**KEY_WIDTH entries per field.
- `VAL_WIDTH`, default 12: dictionary entry width, shared by all fields. Narrower fields use the LSBs.
- `ROM_AW`, default $clog2(NUM_FIELDS*DEPTH): preload ROM address width.

Ports, one per line as name, direction, width, meaning:
- `clk` input 1: the single clock. All logic is on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `start` input 1: level-sampled load request. Ignored while busy.
- `rom_en` output 1: ROM read enable.
- `rom_addr` output ROM_AW: ROM word address.
- `rom_data` input VAL_WIDTH: ROM read data, valid the cycle after the edge that samples `rom_en`/`rom_addr`.
- `write_enable` output NUM_FIELDS: per-field dictionary write enable. One-hot or zero.
- `write_val` output VAL_WIDTH: entry data, common to all fields. Equal to `rom_data`.
- `busy` output 1: high during a load.
- `dict_ready` output 1: high when all dictionaries hold a complete load.
- `load_sum` output VAL_WIDTH: XOR of every word written during the last load.

## Operation
- ROM layout: field f occupies addresses f*DEPTH … f*DEPTH+DEPTH-1, with entry k at offset k.
- FSM states are IDLE, PRIME, LOAD and DONE.
  - IDLE or DONE with `start`=1 goes to PRIME. This clears `dict_ready` and `load_sum`, sets `busy`, drives `rom_en`=1 and `rom_addr`=0.
  - PRIME goes to LOAD unconditionally. `rom_addr` increments to 1.
  - In LOAD, `write_enable[field_idx]`=1 and `load_sum ^= rom_data` every cycle. `rom_addr` increments while it is below NUM_FIELDS*DEPTH-1; after that `rom_en`=0.
  - The entry counter (KEY_WIDTH bits) wraps DEPTH-1→0 and increments `field_idx` at the same time, which moves the active enable to the next field with no idle cycle.
  - LOAD goes to DONE after field NUM_FIELDS-1, entry DEPTH-1 is driven. DONE sets `dict_ready`=1 and `busy`=0.
- `start` asserted in DONE reloads every field. `dict_ready` drops on the PRIME edge.
- `start` asserted in PRIME or LOAD is ignored. It is neither queued nor restarts the load.
- `rom_data` passes to `write_val` combinationally. `write_enable`, `rom_en`, `rom_addr` and the counters are all registered.
- `write_enable` is never high for two fields in the same cycle. Within one field it is never low between entry 0 and entry DEPTH-1.
- Reset values: state IDLE, `rom_en`=0, `rom_addr`=0, `write_enable`=0, `busy`=0, `dict_ready`=0, `load_sum`=0.
- Reset during LOAD:
  - `write_enable` drops asynchronously, so dictionary contents are partial.
  - `dict_ready` stays 0 until a complete new load finishes.
  - No resume: the next `start` reloads from field 0.

## Timing
- Let E0 be the edge that samples `start`=1 in IDLE or DONE.
- Word n (n = 0 … TOTAL-1, TOTAL = NUM_FIELDS*DEPTH) is driven on `write_val` after edge E(n+1) and captured by the dictionary at E(n+2).
- `dict_ready` rises and `busy` falls after E(TOTAL+1). The load therefore occupies TOTAL+1 cycles from E0.
- `rom_addr` = n during the cycle after E(n), for n ≤ TOTAL-1.
- Throughput is one entry per cycle. There are no stalls and no backpressure input.

## Structure
- A shared package `dict_pkg` holds:
  - the FSM state enum `dict_ld_state_t`;
  - the default widths (R-type 5/10, I-type 6/12);
  - the `DICT_DEPTH(kw)` helper.
- The sub-module `dict_ld_counter` holds `field_idx` plus the entry counter with wrap/carry. The FSM, ROM address register and checksum stay at the top level.

## Test plan
- Basic load, NUM_FIELDS=3, KEY_WIDTH=6, ROM word n = n+1:
  - `write_enable`=001 for 64 cycles, then 010 for 64, then 100 for 64, with no gaps;
  - `dict_ready` rises after E193;
  - `load_sum` = XOR of 1…192;
  - reading back field 1, key 0 gives 65.
- Contiguity: monitor `write_enable` each cycle. Require popcount ≤ 1 every cycle and zero-to-one transitions only at entry 0 of each field.
- `start` held high throughout the load: exactly one load of 193 cycles occurs. After `dict_ready` rises, `start` still high immediately triggers a reload and `dict_ready` falls on the next edge.
- Reset mid-load: assert `resetn`=0 asynchronously at word 100 (field 1, entry 36):
  - `write_enable`=0 with no clock edge required;
  - all outputs at reset values;
  - a new `start` gives a full 193-cycle load with correct contents.
- Reload with new ROM contents (word n = 0xFFF-n): all 192 entries overwritten and `load_sum` recomputed.
- KEY_WIDTH=5, VAL_WIDTH=10, NUM_FIELDS=1: 32 writes, `dict_ready` after E33, `rom_addr` never exceeds 31.
